// File: rtl/aes_key_schedule_seq_if.sv
// Round-key streaming interface for aes_key_schedule_seq.
//   start     requester -> expander  begin expansion of key_in
//   key_in    requester -> expander  cipher key, word 0 at the MSBs
//   busy      expander  -> requester expansion in progress
//   rk_valid  expander  -> requester rk_data/rk_index hold a round key
//   rk_ready  requester -> expander  round key accepted when rk_valid && rk_ready
//   rk_data   expander  -> requester {w[4k],w[4k+1],w[4k+2],w[4k+3]}
//   rk_index  expander  -> requester round number k
//   done      expander  -> requester high on the handshake of the last round key
// master = the consumer (cipher datapath), slave = the key expander.
interface aes_key_schedule_seq_if #(
  parameter int KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                busy;
  logic                rk_valid;
  logic                rk_ready;
  logic [127:0]        rk_data;
  logic [3:0]          rk_index;
  logic                done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_data, rk_index, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_data, rk_index, done
  );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES key schedule (AES-128/192/256).
// Produces one 32-bit expanded word per clock through a single SubWord unit
// and streams each group of four words as a 128-bit round key.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   io_ks  slave side of aes_key_schedule_seq_if (start/key_in in,
//          busy/rk_valid/rk_data/rk_index/done out, rk_ready in)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; key window is don't-care
// S_GEN  | generating one word per cycle into the current round key
// S_OUT  | round key presented, waiting for rk_ready
module aes_key_schedule_seq #(
  parameter int KEY_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_schedule_seq_if.slave io_ks
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_key_schedule_seq: KEY_BITS must be 128, 192 or 256");
  end

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_OUT} state_t;

  state_t       r_state;
  state_t       w_state_next;
  // r_win[0] = w[i-NK] ... r_win[NK-1] = w[i-1]
  logic [31:0]  r_win [NK];
  logic [5:0]   r_i;
  logic [2:0]   r_mod;     // i % NK, kept incrementally to avoid a divider
  logic [7:0]   r_rcon;
  logic [127:0] r_rk_data;
  logic [3:0]   r_rk_index;

  logic [31:0]  w_prev;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [31:0]  w_word;
  logic [7:0]   w_rcon_next;
  logic         w_hs;
  logic         w_last;

  assign w_prev = r_win[NK-1];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};
  // One SubWord unit shared between the rotated (i%NK==0) and the
  // AES-256 mid-group (i%NK==4) cases.
  assign w_sub  = sub_word((r_mod == 3'd0) ? w_rot : w_prev);

  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0) begin
      w_temp = w_sub ^ {r_rcon, 24'h0};
    end else if (NK == 8 && r_mod == 3'd4) begin
      w_temp = w_sub;
    end
  end

  // While i < NK the window simply rotates, so r_win[0] walks through the
  // key words and the window holds the key again once i reaches NK.
  assign w_word      = (r_i < 6'(NK)) ? r_win[0] : (r_win[0] ^ w_temp);
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  assign w_hs        = (r_state == S_OUT) && io_ks.rk_ready;
  assign w_last      = (r_rk_index == 4'(NR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (io_ks.start) w_state_next = S_GEN;
      S_GEN:  if (r_i[1:0] == 2'd3) w_state_next = S_OUT;
      S_OUT:  if (io_ks.rk_ready) w_state_next = w_last ? S_IDLE : S_GEN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i        <= '0;
      r_mod      <= '0;
      r_rcon     <= '0;
      r_rk_data  <= '0;
      r_rk_index <= '0;
      for (int j = 0; j < NK; j++) r_win[j] <= '0;
    end else if (r_state == S_IDLE) begin
      if (io_ks.start) begin
        for (int j = 0; j < NK; j++) r_win[j] <= io_ks.key_in[KEY_BITS-1-32*j -: 32];
        r_i    <= '0;
        r_mod  <= '0;
        r_rcon <= 8'h01;
      end
    end else if (r_state == S_GEN) begin
      for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
      r_win[NK-1] <= w_word;
      case (r_i[1:0])
        2'd0: r_rk_data[127:96] <= w_word;
        2'd1: r_rk_data[95:64]  <= w_word;
        2'd2: r_rk_data[63:32]  <= w_word;
        default: r_rk_data[31:0] <= w_word;
      endcase
      if (r_i[1:0] == 2'd3) r_rk_index <= r_i[5:2];
      if (r_i != 6'(NW - 1)) r_i <= r_i + 6'd1;
      r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
      // Advance rcon only when another rcon word is still to come.
      if (r_i >= 6'(NK) && r_mod == 3'd0 && ({1'b0, r_i} + 7'(NK) < 7'(NW)))
        r_rcon <= w_rcon_next;
    end
  end

  assign io_ks.busy     = (r_state != S_IDLE);
  assign io_ks.rk_valid = (r_state == S_OUT);
  assign io_ks.rk_data  = r_rk_data;
  assign io_ks.rk_index = r_rk_index;
  assign io_ks.done     = w_hs && w_last;
endmodule
